// File: rtl/huc1_ir_link_if.sv
// huc1_ir_link_if: cartridge bus seen by the HuC1 infrared link.
//   cart_addr [14:0] : cart address bits 14..0
//   cart_a15         : cart address bit 15
//   cart_wr          : write strobe
//   cart_di   [7:0]  : write data from the CPU
//   ir_do     [7:0]  : IR read byte returned for A000-BFFF in IR mode
// master = CPU/mapper side, slave = IR link.
interface huc1_ir_link_if;
  logic [14:0] cart_addr;
  logic        cart_a15;
  logic        cart_wr;
  logic [7:0]  cart_di;
  logic [7:0]  ir_do;

  modport master (output cart_addr, cart_a15, cart_wr, cart_di, input ir_do);
  modport slave  (input cart_addr, cart_a15, cart_wr, cart_di, output ir_do);
endinterface

// File: rtl/huc1_ir_link.sv
// huc1_ir_link: HuC1 infrared port. Decodes IR-mode writes to A000-BFFF
// into an LED drive with a minimum on-time and a post-off guard window,
// synchronises and debounces the light sensor, and returns C0/C1 for reads.
//   clk_sys, reset   : clock, synchronous active-high reset
//   ce_cpu           : CPU tick enable, all timing counts in these ticks
//   enable           : mapper selected; low holds the reset state
//   ir_en            : IR mode from the mapper
//   cart             : cart bus (slave modport), supplies ir_do
//   ir_rx / ir_tx    : light sensor in (async) / LED out
//   savestate_*      : {rx_state, led_reg} save/restore
//
// state   | meaning
// S_IDLE  | LED off, sensor live
// S_ON    | LED on, minimum on-time running
// S_HOLD  | LED requested off, finishing the minimum on-time
// S_GUARD | LED off, sensor ignored until the guard expires
module huc1_ir_link #(
  parameter int STRETCH_TICKS  = 64,
  parameter int GUARD_TICKS    = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_cpu,
  input  logic          enable,
  input  logic          ir_en,
  huc1_ir_link_if.slave cart,
  input  logic          ir_rx,
  output logic          ir_tx,
  input  logic          savestate_load,
  input  logic [15:0]   savestate_data,
  output logic [15:0]   savestate_back
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_HOLD, S_GUARD} state_t;

  localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_TICKS - 1);
  localparam logic [7:0] GUARD_LOAD   = 8'(GUARD_TICKS);
  localparam logic [3:0] DEB_LAST     = 4'(DEBOUNCE_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  deb_q, deb_d;
  logic        led_q, led_d;
  logic        rx_state_q, rx_state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        ir_en_prev_q, ir_en_prev_d;
  logic        ir_tx_q, ir_tx_d;

  logic        wr_hit;
  logic        ir_en_fall;
  logic [7:0]  cnt_dec;
  logic        unused_bits;

  assign wr_hit = ce_cpu & cart.cart_wr & cart.cart_a15 &
                  (cart.cart_addr[14:13] == 2'b01) & ir_en;
  assign ir_en_fall = ir_en_prev_q & ~ir_en;
  // Counter saturates at zero; it only moves on CPU ticks.
  assign cnt_dec = (ce_cpu && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;

  assign unused_bits = ^{cart.cart_addr[12:0], cart.cart_di[7:1], savestate_data[15:2]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    deb_d        = deb_q;
    led_d        = led_q;
    rx_state_d   = rx_state_q;
    sync1_d      = ir_rx;
    sync2_d      = sync1_q;
    ir_en_prev_d = ir_en;

    if (!enable) begin
      state_d      = S_IDLE;
      cnt_d        = 8'd0;
      deb_d        = 4'd0;
      led_d        = 1'b0;
      rx_state_d   = 1'b0;
      sync1_d      = 1'b0;
      sync2_d      = 1'b0;
      ir_en_prev_d = 1'b0;
    end else if (savestate_load) begin
      state_d    = S_IDLE;
      cnt_d      = 8'd0;
      deb_d      = 4'd0;
      led_d      = savestate_data[0];
      rx_state_d = savestate_data[1];
    end else begin
      if (wr_hit) led_d = cart.cart_di[0];

      // FSM reacts to the registered led_q, so a write is seen one cycle later.
      unique case (state_q)
        S_IDLE: begin
          if (led_q) begin
            state_d = S_ON;
            cnt_d   = STRETCH_LOAD;
          end
        end
        S_ON: begin
          if (!led_q && cnt_q == 8'd0) begin
            state_d = S_GUARD;
            cnt_d   = GUARD_LOAD;
          end else begin
            if (!led_q) state_d = S_HOLD;
            cnt_d = cnt_dec;
          end
        end
        S_HOLD: begin
          if (led_q) begin
            state_d = S_ON;
            cnt_d   = cnt_dec;
          end else if (cnt_q == 8'd0) begin
            state_d = S_GUARD;
            cnt_d   = GUARD_LOAD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        S_GUARD: begin
          if (led_q) begin
            state_d = S_ON;
            cnt_d   = STRETCH_LOAD;
          end else if (cnt_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Leaving IR mode kills the LED outright, no stretch and no guard.
      if (ir_en_fall) begin
        led_d   = 1'b0;
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end

      // Sensor is frozen whenever our own LED could be lighting it.
      if (state_q != S_IDLE || sync2_q == rx_state_q) begin
        deb_d = 4'd0;
      end else if (ce_cpu) begin
        if (deb_q == DEB_LAST) begin
          rx_state_d = sync2_q;
          deb_d      = 4'd0;
        end else begin
          deb_d = deb_q + 4'd1;
        end
      end
    end

    ir_tx_d = (state_d == S_ON) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      deb_q        <= 4'd0;
      led_q        <= 1'b0;
      rx_state_q   <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      ir_en_prev_q <= 1'b0;
      ir_tx_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      deb_q        <= deb_d;
      led_q        <= led_d;
      rx_state_q   <= rx_state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      ir_en_prev_q <= ir_en_prev_d;
      ir_tx_q      <= ir_tx_d;
    end
  end

  assign ir_tx          = ir_tx_q;
  assign cart.ir_do     = {7'b1100000, rx_state_q};
  assign savestate_back = {14'b0, rx_state_q, led_q};

endmodule

// File: tb/tb_huc1_ir_link.sv
// Directed bench for huc1_ir_link with default parameters (64/16/4).
module tb_huc1_ir_link;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_cpu;
  logic        enable;
  logic        ir_en;
  logic        ir_rx;
  logic        ir_tx;
  logic        savestate_load;
  logic [15:0] savestate_data;
  logic [15:0] savestate_back;

  int checks = 0;
  int errors = 0;

  huc1_ir_link_if bus ();

  huc1_ir_link dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ce_cpu         (ce_cpu),
    .enable         (enable),
    .ir_en          (ir_en),
    .cart           (bus.slave),
    .ir_rx          (ir_rx),
    .ir_tx          (ir_tx),
    .savestate_load (savestate_load),
    .savestate_data (savestate_data),
    .savestate_back (savestate_back)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_write(input logic a15, input logic [14:0] addr, input logic [7:0] data);
    bus.cart_a15  = a15;
    bus.cart_addr = addr;
    bus.cart_di   = data;
    bus.cart_wr   = 1'b1;
    tick(1);
    bus.cart_wr   = 1'b0;
  endtask

  task automatic ss_load(input logic [15:0] data);
    savestate_data = data;
    savestate_load = 1'b1;
    tick(1);
    savestate_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce_cpu = 1'b1; enable = 1'b1; ir_en = 1'b1; ir_rx = 1'b0;
    savestate_load = 1'b0; savestate_data = 16'h0;
    bus.cart_a15 = 1'b0; bus.cart_addr = 15'h0; bus.cart_wr = 1'b0; bus.cart_di = 8'h0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // 1: reset state and write-to-LED latency
    check_val("rst_tx", {15'b0, ir_tx}, 16'h0);
    check_val("rst_do", {8'b0, bus.ir_do}, 16'h00C0);
    check_val("rst_back", savestate_back, 16'h0);
    bus_write(1'b1, 15'h2000, 8'h01);
    check_val("wr_same_cycle", {15'b0, ir_tx}, 16'h0);
    tick(1);
    check_val("wr_latency", {15'b0, ir_tx}, 16'h1);

    // 2: stretch to 64 ticks, guard masks the sensor
    tick(8);
    bus_write(1'b1, 15'h2000, 8'h00);
    tick(54);
    check_val("stretch_last", {15'b0, ir_tx}, 16'h1);
    tick(1);
    check_val("stretch_end", {15'b0, ir_tx}, 16'h0);
    ir_rx = 1'b1;
    tick(12);
    check_val("guard_mask", {8'b0, bus.ir_do}, 16'h00C0);
    ir_rx = 1'b0;
    tick(20);
    check_val("guard_after", {8'b0, bus.ir_do}, 16'h00C0);

    // 3: debounce boundaries
    ir_rx = 1'b1;
    tick(5);
    check_val("deb_3", {8'b0, bus.ir_do}, 16'h00C0);
    tick(1);
    check_val("deb_4", {8'b0, bus.ir_do}, 16'h00C1);
    ir_rx = 1'b0;
    tick(8);
    check_val("deb_fall", {8'b0, bus.ir_do}, 16'h00C0);
    ir_rx = 1'b1; tick(3); ir_rx = 1'b0;
    tick(10);
    check_val("pulse_3", {8'b0, bus.ir_do}, 16'h00C0);
    ir_rx = 1'b1; tick(4); ir_rx = 1'b0;
    tick(3);
    check_val("pulse_4", {8'b0, bus.ir_do}, 16'h00C1);
    ce_cpu = 1'b0;
    tick(20);
    check_val("deb_no_ce", {8'b0, bus.ir_do}, 16'h00C1);
    ce_cpu = 1'b1;
    tick(8);
    check_val("deb_ce_back", {8'b0, bus.ir_do}, 16'h00C0);

    // address and data decode
    bus_write(1'b1, 15'h0000, 8'h01); tick(2);
    check_val("dec_8000", {15'b0, ir_tx}, 16'h0);
    bus_write(1'b1, 15'h4000, 8'h01); tick(2);
    check_val("dec_c000", {15'b0, ir_tx}, 16'h0);
    bus_write(1'b0, 15'h2000, 8'h01); tick(2);
    check_val("dec_2000", {15'b0, ir_tx}, 16'h0);
    bus_write(1'b1, 15'h3FFF, 8'hFE); tick(2);
    check_val("dec_bit0", {15'b0, ir_tx}, 16'h0);
    ce_cpu = 1'b0;
    bus_write(1'b1, 15'h2000, 8'h01); tick(2);
    ce_cpu = 1'b1;
    check_val("dec_no_ce", {15'b0, ir_tx}, 16'h0);

    // counter frozen without ce_cpu
    bus_write(1'b1, 15'h3FFF, 8'h01);
    bus_write(1'b1, 15'h2000, 8'h00);
    ce_cpu = 1'b0;
    tick(200);
    check_val("hold_no_ce", {15'b0, ir_tx}, 16'h1);
    ce_cpu = 1'b1;
    tick(70);
    check_val("hold_ce_end", {15'b0, ir_tx}, 16'h0);
    tick(20);

    // 4: ir_en gating and ir_en falling edge
    ir_en = 1'b0;
    bus_write(1'b1, 15'h2000, 8'h01); tick(2);
    check_val("ram_wr_tx", {15'b0, ir_tx}, 16'h0);
    check_val("ram_wr_led", savestate_back, 16'h0);
    ir_en = 1'b1; tick(1);
    bus_write(1'b1, 15'h2000, 8'h01); tick(1);
    check_val("ir_en_on", {15'b0, ir_tx}, 16'h1);
    ir_en = 1'b0; tick(1);
    check_val("ir_en_fall_tx", {15'b0, ir_tx}, 16'h0);
    check_val("ir_en_fall_led", savestate_back, 16'h0);
    tick(3);
    check_val("ir_en_fall_idle", {15'b0, ir_tx}, 16'h0);
    ir_en = 1'b1; tick(2);

    // 5: savestate
    ir_rx = 1'b1; tick(8);
    check_val("ss_rx", {8'b0, bus.ir_do}, 16'h00C1);
    bus_write(1'b1, 15'h2000, 8'h01); tick(2);
    check_val("ss_back", savestate_back, 16'h0003);
    ss_load(16'h0002);
    check_val("ss_ld2_tx", {15'b0, ir_tx}, 16'h0);
    check_val("ss_ld2_do", {8'b0, bus.ir_do}, 16'h00C1);
    check_val("ss_ld2_back", savestate_back, 16'h0002);
    ir_rx = 1'b0;
    ss_load(16'h0001);
    check_val("ss_ld1_tx0", {15'b0, ir_tx}, 16'h0);
    tick(1);
    check_val("ss_ld1_tx1", {15'b0, ir_tx}, 16'h1);
    ss_load(16'h0000);
    tick(20);

    // 6: enable dropped mid-HOLD
    ir_rx = 1'b1; tick(8);
    bus_write(1'b1, 15'h2000, 8'h01); tick(3);
    bus_write(1'b1, 15'h2000, 8'h00); tick(2);
    check_val("hold_tx", {15'b0, ir_tx}, 16'h1);
    enable = 1'b0; tick(1);
    check_val("dis_tx", {15'b0, ir_tx}, 16'h0);
    check_val("dis_do", {8'b0, bus.ir_do}, 16'h00C0);
    check_val("dis_back", savestate_back, 16'h0);
    ir_rx = 1'b0;
    enable = 1'b1; tick(3);
    check_val("reen_tx", {15'b0, ir_tx}, 16'h0);
    check_val("reen_back", savestate_back, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
